seg7_scan_n: RTL and testbench

Parametrised multiplexed N-digit 7-segment display driver. It is the successor to the fixed 4-digit LUT scanner that is clocked from a divided counter bit.
- Runs on the system clock with an internal refresh prescaler.
- Adds anti-ghosting blank slots, per-digit enable, decimal points, leading-zero suppression and frame-synchronous tear-free data capture.
- Sits between the CPU GPIO bus and the board's segment/digit pins.

---
 rtl/seg7_scan_n_if.sv | 24 ++
 rtl/seg7_scan_n.sv | 182 ++++++++++++++++++
 tb/tb_seg7_scan_n.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_n_if.sv
// GPIO-side bundle for the multiplexed 7-segment scanner: display data in,
// segment/digit pin drive and frame strobe out.
interface seg7_scan_n_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] idata;
    logic [DIGITS-1:0]   idp;
    logic [DIGITS-1:0]   ien;
    logic                ilz_blank;
    logic [6:0]          oseg;
    logic                odp;
    logic [DIGITS-1:0]   odig;
    logic                oframe;

    modport master (
        output idata, idp, ien, ilz_blank,
        input  oseg, odp, odig, oframe
    );

    modport slave (
        input  idata, idp, ien, ilz_blank,
        output oseg, odp, odig, oframe
    );
endinterface

// File: rtl/seg7_scan_n.sv
// N-digit multiplexed 7-segment driver with blank slots between digits,
// leading-zero suppression and whole-frame shadow capture of the display data.
module seg7_scan_n #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    seg7_scan_n_if.slave bus
);
    localparam int CNT_RANGE = (REFRESH_DIV > BLANK_CYCLES)
                             ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                             : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CW = $clog2(CNT_RANGE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]     BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] r_shadow_data;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [DIGITS-1:0]   r_shadow_en;
    logic                r_load_pending;
    logic [6:0]          r_oseg;
    logic                r_odp;
    logic [DIGITS-1:0]   r_odig;
    logic                r_oframe;

    logic [DIGITS-1:0]   w_nib_zero;
    logic [DIGITS-1:0]   w_zero_from;
    logic [3:0]          w_sel_nib;
    logic                w_sel_dp;
    logic                w_sel_en;
    logic                w_sel_zero;
    logic [DIGITS-1:0]   w_sel_onehot;
    logic                w_lit;
    logic                w_lz_blank;
    logic [6:0]          w_seg_ah;
    logic                w_dp_ah;
    logic [DIGITS-1:0]   w_dig_ah;
    logic                w_wrap;
    logic [IW-1:0]       w_idx_next;
    logic                w_slot_end;
    logic                w_blank_end;
    logic                w_advance;
    logic                w_capture;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    // w_zero_from[i] is set when shadow nibbles i..DIGITS-1 are all zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            assign w_nib_zero[gi] = (r_shadow_data[4*gi +: 4] == 4'h0);
            if (gi == DIGITS - 1) begin : g_top
                assign w_zero_from[gi] = w_nib_zero[gi];
            end else begin : g_chain
                assign w_zero_from[gi] = w_nib_zero[gi] & w_zero_from[gi+1];
            end
        end
    endgenerate

    always_comb begin
        w_sel_nib    = 4'h0;
        w_sel_dp     = 1'b0;
        w_sel_en     = 1'b0;
        w_sel_zero   = 1'b0;
        w_sel_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_sel_nib       = r_shadow_data[4*i +: 4];
                w_sel_dp        = r_shadow_dp[i];
                w_sel_en        = r_shadow_en[i];
                w_sel_zero      = w_zero_from[i];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    // A suppressed leading zero keeps its digit selected so its dp can still light.
    assign w_lit      = (r_state == ST_SHOW) && w_sel_en;
    assign w_lz_blank = bus.ilz_blank && (r_idx != '0) && w_sel_zero;
    assign w_seg_ah   = (w_lit && !w_lz_blank) ? hex_decode(w_sel_nib) : 7'h00;
    assign w_dp_ah    = w_lit & w_sel_dp;
    assign w_dig_ah   = w_lit ? w_sel_onehot : '0;

    assign w_wrap      = (r_idx == IDX_LAST);
    assign w_idx_next  = w_wrap ? '0 : r_idx + 1'b1;
    assign w_slot_end  = (r_state == ST_SHOW) && (r_cnt == SHOW_LAST);
    assign w_blank_end = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
    assign w_advance   = (w_slot_end && (BLANK_CYCLES == 0)) || w_blank_end;
    assign w_capture   = r_load_pending || (w_advance && w_wrap);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_SHOW;
            r_idx          <= '0;
            r_cnt          <= '0;
            r_shadow_data  <= '0;
            r_shadow_dp    <= '0;
            r_shadow_en    <= '0;
            r_load_pending <= 1'b1;
            r_oseg         <= SEG_OFF;
            r_odp          <= DP_OFF;
            r_odig         <= DIG_OFF;
            r_oframe       <= 1'b0;
        end else begin
            r_load_pending <= 1'b0;
            r_oframe       <= w_capture;
            if (w_capture) begin
                r_shadow_data <= bus.idata;
                r_shadow_dp   <= bus.idp;
                r_shadow_en   <= bus.ien;
            end
            if (w_advance) begin
                r_idx <= w_idx_next;
            end
            case (r_state)
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        r_cnt <= '0;
                        if (BLANK_CYCLES > 0) begin
                            r_state <= ST_BLANK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
            r_oseg <= SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
            r_odp  <= SEG_ACTIVE_LOW ? ~w_dp_ah  : w_dp_ah;
            r_odig <= DIG_ACTIVE_LOW ? ~w_dig_ah : w_dig_ah;
        end
    end

    assign bus.oseg   = r_oseg;
    assign bus.odp    = r_odp;
    assign bus.odig   = r_odig;
    assign bus.oframe = r_oframe;
endmodule

// File: tb/tb_seg7_scan_n.sv
// Scoreboard bench: two scanner configurations, expected samples queued by
// cycle number after reset release, popped and compared by a negedge monitor.
module tb_seg7_scan_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_n_if #(.DIGITS(4)) bus_a ();
    seg7_scan_n_if #(.DIGITS(1)) bus_b ();

    seg7_scan_n #(
        .DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    seg7_scan_n #(
        .DIGITS(1), .REFRESH_DIV(4), .BLANK_CYCLES(0),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int         cyc;
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    // cyc = posedges since reset release; 0 while reset is held
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic void pa(int c, logic [3:0] d, logic [6:0] s, logic p, logic f);
        exp_t e;
        e.cyc = c; e.dig = d; e.seg = s; e.dp = p; e.frame = f;
        qa.push_back(e);
    endfunction

    function automatic void pb(int c, logic [3:0] d, logic [6:0] s, logic p, logic f);
        exp_t e;
        e.cyc = c; e.dig = d; e.seg = s; e.dp = p; e.frame = f;
        qb.push_back(e);
    endfunction

    task automatic check(string name, exp_t e, logic [3:0] dig, logic [6:0] seg,
                         logic dp, logic fr);
        n_vec++;
        if (dig !== e.dig || seg !== e.seg || dp !== e.dp || fr !== e.frame) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got dig=%h seg=%h dp=%b frame=%b required dig=%h seg=%h dp=%b frame=%b",
                     name, e.cyc, dig, seg, dp, fr, e.dig, e.seg, e.dp, e.frame);
        end else begin
            $display("ok   %s cyc=%0d dig=%h seg=%h dp=%b frame=%b",
                     name, e.cyc, dig, seg, dp, fr);
        end
    endtask

    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            ea = qa.pop_front();
            if (ea.cyc < cyc) begin
                n_vec++; n_fail++;
                $display("FAIL cfgA missed sample cyc=%0d at cyc=%0d", ea.cyc, cyc);
            end else begin
                check("cfgA", ea, bus_a.odig, bus_a.oseg, bus_a.odp, bus_a.oframe);
            end
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            eb = qb.pop_front();
            if (eb.cyc < cyc) begin
                n_vec++; n_fail++;
                $display("FAIL cfgB missed sample cyc=%0d at cyc=%0d", eb.cyc, cyc);
            end else begin
                check("cfgB", eb, {3'b000, bus_b.odig}, bus_b.oseg, bus_b.odp, bus_b.oframe);
            end
        end
    end

    task automatic wait_cyc(int n);
        for (int i = 0; i < 300 && cyc < n; i++) @(negedge clk);
        if (cyc < n) begin
            n_vec++; n_fail++;
            $display("FAIL wait_cyc timeout got cyc=%0d required %0d", cyc, n);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        if (qa.size() > 0 || qb.size() > 0) begin
            n_vec++; n_fail++;
            $display("FAIL drain timeout got %0d/%0d pending required 0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    initial begin
        bus_a.idata = 16'h1234; bus_a.idp = 4'b0000; bus_a.ien = 4'hF; bus_a.ilz_blank = 1'b0;
        bus_b.idata = 4'h8;     bus_b.idp = 1'b0;    bus_b.ien = 1'b1; bus_b.ilz_blank = 1'b0;

        // held in reset: all outputs inactive
        pa(0, 4'hF, 7'h7F, 1'b1, 1'b0);
        pb(0, 4'h0, 7'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // scan order, blanking, frame strobes and tear-free update 1234 -> ABCD
        pa(1,  4'hF, 7'h7F, 1'b1, 1'b1);
        pa(2,  4'hE, 7'h19, 1'b1, 1'b0);
        pa(5,  4'hF, 7'h7F, 1'b1, 1'b0);
        pa(8,  4'hD, 7'h30, 1'b1, 1'b0);
        pa(11, 4'hF, 7'h7F, 1'b1, 1'b0);
        pa(14, 4'hB, 7'h24, 1'b1, 1'b0);
        pa(20, 4'h7, 7'h79, 1'b1, 1'b0);
        pa(23, 4'hF, 7'h7F, 1'b1, 1'b0);
        pa(24, 4'hF, 7'h7F, 1'b1, 1'b1);
        pa(25, 4'hE, 7'h21, 1'b1, 1'b0);
        pa(32, 4'hD, 7'h46, 1'b1, 1'b0);
        pa(38, 4'hB, 7'h03, 1'b1, 1'b0);
        pa(44, 4'h7, 7'h08, 1'b1, 1'b0);
        pa(48, 4'hF, 7'h7F, 1'b1, 1'b1);
        pb(1, 4'h0, 7'h00, 1'b0, 1'b1);
        for (int c = 2; c <= 24; c++)
            pb(c, 4'h1, (c >= 17) ? 7'h4F : 7'h7F, 1'b0, (c % 4) == 0);
        rst = 1'b1;
        wait_cyc(13);
        bus_a.idata = 16'hABCD;
        bus_b.idata = 4'h3;
        wait_drain();

        // reset asserted between edges must clear outputs before the next edge
        @(posedge clk);
        #2;
        rst = 1'b0;
        pa(0, 4'hF, 7'h7F, 1'b1, 1'b0);
        pb(0, 4'h0, 7'h00, 1'b0, 1'b0);
        bus_a.idata = 16'h0050; bus_a.idp = 4'b1000; bus_a.ien = 4'hF; bus_a.ilz_blank = 1'b1;
        bus_b.idp = 1'b1;
        repeat (2) @(negedge clk);

        // leading zeros on/off, then digit enables, dp and the all-zero boundary
        pa(2,  4'hE, 7'h40, 1'b1, 1'b0);
        pa(8,  4'hD, 7'h12, 1'b1, 1'b0);
        pa(14, 4'hB, 7'h7F, 1'b1, 1'b0);
        pa(20, 4'h7, 7'h7F, 1'b0, 1'b0);
        pa(24, 4'hF, 7'h7F, 1'b1, 1'b1);
        pa(38, 4'hB, 7'h40, 1'b1, 1'b0);
        pa(44, 4'h7, 7'h40, 1'b0, 1'b0);
        pa(50, 4'hE, 7'h40, 1'b0, 1'b0);
        pa(56, 4'hF, 7'h7F, 1'b1, 1'b0);
        pa(62, 4'hB, 7'h7F, 1'b1, 1'b0);
        pa(68, 4'hF, 7'h7F, 1'b1, 1'b0);
        pa(72, 4'hF, 7'h7F, 1'b1, 1'b1);
        pb(1, 4'h0, 7'h00, 1'b0, 1'b1);
        pb(2, 4'h1, 7'h4F, 1'b1, 1'b0);
        pb(4, 4'h1, 7'h4F, 1'b1, 1'b1);
        rst = 1'b1;
        wait_cyc(22);
        bus_a.ilz_blank = 1'b0;
        wait_cyc(45);
        bus_a.ilz_blank = 1'b1;
        bus_a.idata     = 16'h0000;
        bus_a.ien       = 4'b0101;
        bus_a.idp       = 4'b0001;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
